// File: rtl/eval_pkg.sv
// eval_pkg: shared constants and FSM state type for the f(x) evaluation
// scheduler.
//   FP_128    : 128.0 in single precision, the argument offset
//   FP_HALF   : 0.5, the linear-term coefficient
//   FP_INV128 : 2^-7, the argument scale
//   FP_QNAN   : the result returned on timeout
package eval_pkg;

    localparam logic [31:0] FP_128    = 32'h4300_0000;
    localparam logic [31:0] FP_HALF   = 32'h3F00_0000;
    localparam logic [31:0] FP_INV128 = 32'h3C00_0000;
    localparam logic [31:0] FP_QNAN   = 32'h7FC0_0000;

    typedef enum logic [3:0] {
        IDLE,
        SUB,
        SCALE,
        COS_SQ,
        HALF,
        WAIT_COS,
        MUL3,
        ADD,
        FIN
    } state_t;

endpackage

// File: rtl/eval_wait_timer.sv
// eval_wait_timer: per-wait timeout counter for the scheduler.
//   clock, reset  : system clock, async active-low reset
//   clk_en        : global enable, counter frozen when low
//   clear         : restart the count (asserted on every unit issue)
//   enable        : a unit result is being awaited
//   expired       : TIMEOUT_CYCLES enabled wait cycles have elapsed
module eval_wait_timer #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic clk_en,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

    logic [W-1:0] cnt;

    // Saturates at LIMIT so expired stays asserted until the FSM reacts.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clk_en) begin
            if (clear)
                cnt <= '0;
            else if (enable && cnt != LIMIT)
                cnt <= cnt + 1'b1;
        end
    end

    // During the issue cycle the count still holds the previous wait's value,
    // so clear masks it.
    assign expired = enable && !clear && (cnt == LIMIT);

endmodule

// File: rtl/eval_scheduler.sv
// eval_scheduler: sequences shared FP add/sub, multiplier and CORDIC cosine
// units to compute f(x) = 0.5*x + x^2 * cos((x-128)/128).
//   clock, reset, clk_en     : clock, async active-low reset, global enable
//   start, dataa             : request pulse and single-precision x
//   done, result, busy, error: completion pulse, held result, busy, timeout
//   as_*                     : add/sub unit request/response (as_op 1=sub)
//   mul_*                    : multiplier request/response
//   cos_*                    : cosine request/response
module eval_scheduler
    import eval_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clk_en,
    input  logic        start,
    input  logic [31:0] dataa,
    output logic        done,
    output logic [31:0] result,
    output logic        busy,
    output logic        error,
    output logic        as_start,
    output logic        as_op,
    output logic [31:0] as_a,
    output logic [31:0] as_b,
    input  logic        as_done,
    input  logic [31:0] as_result,
    output logic        mul_start,
    output logic [31:0] mul_a,
    output logic [31:0] mul_b,
    input  logic        mul_done,
    input  logic [31:0] mul_result,
    output logic        cos_start,
    output logic [31:0] cos_arg,
    input  logic        cos_done,
    input  logic [31:0] cos_result
);

    state_t      state;
    logic [31:0] x_r, sq_r, half_r, cos_r;
    logic        cos_seen;
    logic        awaited;
    logic        waiting;
    logic        tmr_clear;
    logic        expired;

    // Done pulse of the unit the current state is waiting on; other done
    // pulses do not advance the sequence.
    always_comb begin
        awaited = 1'b0;
        case (state)
            SUB, ADD:                  awaited = as_done;
            SCALE, COS_SQ, HALF, MUL3: awaited = mul_done;
            WAIT_COS:                  awaited = cos_done;
            default:                   awaited = 1'b0;
        endcase
    end

    assign waiting   = (state != IDLE) && (state != FIN);
    assign tmr_clear = (state == IDLE) || as_start || mul_start || cos_start;

    eval_wait_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .clk_en (clk_en),
        .clear  (tmr_clear),
        .enable (waiting),
        .expired(expired)
    );

    // Each state is the wait for the op issued on entry; operands are
    // registered with the start pulse and held until the next issue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            x_r       <= '0;
            sq_r      <= '0;
            half_r    <= '0;
            cos_r     <= '0;
            cos_seen  <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            busy      <= 1'b0;
            error     <= 1'b0;
            as_start  <= 1'b0;
            as_op     <= 1'b0;
            as_a      <= '0;
            as_b      <= '0;
            mul_start <= 1'b0;
            mul_a     <= '0;
            mul_b     <= '0;
            cos_start <= 1'b0;
            cos_arg   <= '0;
        end else if (clk_en) begin
            as_start  <= 1'b0;
            mul_start <= 1'b0;
            cos_start <= 1'b0;
            done      <= 1'b0;

            // Cosine runs alongside the two multiplies; grab it whenever it lands.
            if ((state == COS_SQ || state == HALF || state == WAIT_COS) && cos_done) begin
                cos_r    <= cos_result;
                cos_seen <= 1'b1;
            end

            case (state)
                IDLE: if (start) begin
                    x_r      <= dataa;
                    as_a     <= dataa;
                    as_b     <= FP_128;
                    as_op    <= 1'b1;
                    as_start <= 1'b1;
                    busy     <= 1'b1;
                    error    <= 1'b0;
                    state    <= SUB;
                end
                SUB: if (as_done) begin
                    mul_a     <= as_result;
                    mul_b     <= FP_INV128;
                    mul_start <= 1'b1;
                    state     <= SCALE;
                end
                SCALE: if (mul_done) begin
                    cos_arg   <= mul_result;
                    cos_start <= 1'b1;
                    cos_seen  <= 1'b0;
                    mul_a     <= x_r;
                    mul_b     <= x_r;
                    mul_start <= 1'b1;
                    state     <= COS_SQ;
                end
                COS_SQ: if (mul_done) begin
                    sq_r      <= mul_result;
                    mul_a     <= x_r;
                    mul_b     <= FP_HALF;
                    mul_start <= 1'b1;
                    state     <= HALF;
                end
                HALF: if (mul_done) begin
                    half_r <= mul_result;
                    // Skip WAIT_COS when the cosine is already in hand so the
                    // final multiply issues on the very next cycle.
                    if (cos_seen || cos_done) begin
                        mul_a     <= sq_r;
                        mul_b     <= cos_seen ? cos_r : cos_result;
                        mul_start <= 1'b1;
                        state     <= MUL3;
                    end else begin
                        state <= WAIT_COS;
                    end
                end
                WAIT_COS: if (cos_done) begin
                    mul_a     <= sq_r;
                    mul_b     <= cos_result;
                    mul_start <= 1'b1;
                    state     <= MUL3;
                end
                MUL3: if (mul_done) begin
                    as_a     <= half_r;
                    as_b     <= mul_result;
                    as_op    <= 1'b0;
                    as_start <= 1'b1;
                    state    <= ADD;
                end
                ADD: if (as_done) begin
                    result <= as_result;
                    done   <= 1'b1;
                    state  <= FIN;
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            // Overrides any state action above.
            if (waiting && !awaited && expired) begin
                result <= FP_QNAN;
                error  <= 1'b1;
                done   <= 1'b1;
                state  <= FIN;
            end
        end
    end

endmodule

// File: tb/tb_eval_scheduler.sv
// tb_eval_scheduler: randomized self-checking bench for eval_scheduler.
// Unit models return real-arithmetic results rounded to single precision
// after programmable latencies; the reference evaluates f(x) directly.
module tb_eval_scheduler;

    localparam int TMO = 16;
    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clk_en = 1'b1;
    logic        start = 1'b0;
    logic [31:0] dataa = '0;
    logic        done, busy, error;
    logic [31:0] result;
    logic        as_start, as_op, mul_start, cos_start;
    logic [31:0] as_a, as_b, mul_a, mul_b, cos_arg;
    logic        as_done_m = 1'b0, mul_done_m = 1'b0, cos_done_m = 1'b0;
    logic        inj_as = 1'b0, inj_mul = 1'b0, inj_cos = 1'b0;
    logic        as_done_w, mul_done_w, cos_done_w;
    logic [31:0] as_res = '0, mul_res = '0, cos_res = '0;

    int ls = 3, lm = 2, lc = 4;
    bit mul_hang = 1'b0;
    int as_r = 0, mul_r = 0, cos_r = 0;
    int cyc = 0;
    int n_tests = 0, n_fail = 0;
    int last_lat = 0;
    logic [31:0] last_cos_arg = '0;

    assign as_done_w  = as_done_m | inj_as;
    assign mul_done_w = mul_done_m | inj_mul;
    assign cos_done_w = cos_done_m | inj_cos;

    eval_scheduler #(.TIMEOUT_CYCLES(TMO)) dut (
        .clock(clock), .reset(reset), .clk_en(clk_en), .start(start), .dataa(dataa),
        .done(done), .result(result), .busy(busy), .error(error),
        .as_start(as_start), .as_op(as_op), .as_a(as_a), .as_b(as_b),
        .as_done(as_done_w), .as_result(as_res),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
        .mul_done(mul_done_w), .mul_result(mul_res),
        .cos_start(cos_start), .cos_arg(cos_arg),
        .cos_done(cos_done_w), .cos_result(cos_res)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic real from_f32(input logic [31:0] b);
        logic [63:0] d;
        if (b[30:23] == 8'd0) d = {b[31], 63'd0};
        else d = {b[31], 11'(b[30:23]) + 11'd896, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    // Round-to-nearest-even from double; tiny values flush to zero.
    function automatic logic [31:0] to_f32(input real r);
        logic [63:0] d;
        logic [10:0] e;
        logic [31:0] m;
        d = $realtobits(r);
        e = d[62:52];
        if (e < 11'd897) return {d[63], 31'd0};
        m = {1'b0, 8'(e - 11'd896), d[51:29]};
        if (d[28] && ((|d[27:0]) || d[29])) m = m + 1;
        return {d[63], m[30:0]};
    endfunction

    function automatic logic [31:0] ref_f(input logic [31:0] x);
        real xv;
        logic [31:0] arg, sq, c, h, p;
        xv  = from_f32(x);
        arg = to_f32(from_f32(to_f32(xv - 128.0)) / 128.0);
        c   = to_f32($cos(from_f32(arg)));
        sq  = to_f32(xv * xv);
        h   = to_f32(xv * 0.5);
        p   = to_f32(from_f32(sq) * from_f32(c));
        return to_f32(from_f32(h) + from_f32(p));
    endfunction

    function automatic logic [31:0] rand_x();
        logic [7:0] e;
        e = 8'($urandom_range(140, 118));
        return {1'($urandom_range(1, 0)), e, 23'($urandom)};
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            as_r <= 0; as_done_m <= 1'b0; as_res <= '0;
        end else if (clk_en) begin
            if (as_start) begin
                as_r      <= ls - 1;
                as_done_m <= (ls == 1);
                as_res    <= to_f32(as_op ? from_f32(as_a) - from_f32(as_b)
                                          : from_f32(as_a) + from_f32(as_b));
            end else if (as_r > 0) begin
                as_r      <= as_r - 1;
                as_done_m <= (as_r == 1);
            end else as_done_m <= 1'b0;
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            mul_r <= 0; mul_done_m <= 1'b0; mul_res <= '0;
        end else if (clk_en) begin
            if (mul_start) begin
                mul_r      <= mul_hang ? 0 : lm - 1;
                mul_done_m <= !mul_hang && (lm == 1);
                mul_res    <= to_f32(from_f32(mul_a) * from_f32(mul_b));
            end else if (mul_r > 0) begin
                mul_r      <= mul_r - 1;
                mul_done_m <= (mul_r == 1);
            end else mul_done_m <= 1'b0;
        end
    end

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            cos_r <= 0; cos_done_m <= 1'b0; cos_res <= '0;
        end else if (clk_en) begin
            if (cos_start) begin
                cos_r        <= lc - 1;
                cos_done_m   <= (lc == 1);
                cos_res      <= to_f32($cos(from_f32(cos_arg)));
                last_cos_arg <= cos_arg;
            end else if (cos_r > 0) begin
                cos_r      <= cos_r - 1;
                cos_done_m <= (cos_r == 1);
            end else cos_done_m <= 1'b0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One request. stall_at>=0 drops clk_en for 5 cycles at that offset;
    // poke adds a start while busy and a start in the done cycle.
    task automatic run(input logic [31:0] x, input int stall_at, input bit poke, input bit exp_err);
        int c0, lat, exp_lat, n;
        bit seen;
        logic [31:0] ex;
        ex = exp_err ? QNAN : ref_f(x);
        @(posedge clock); #1;
        start = 1'b1; dataa = x; c0 = cyc;
        seen = 1'b0; lat = 0;
        for (int i = 1; i <= 300 && !seen; i++) begin
            @(posedge clock); #1;
            start = 1'b0;
            if (poke && cyc - c0 == 3) begin start = 1'b1; dataa = ~x; end
            if (stall_at >= 0 && cyc - c0 == stall_at) clk_en = 1'b0;
            if (stall_at >= 0 && cyc - c0 == stall_at + 5) clk_en = 1'b1;
            @(negedge clock);
            if (cyc - c0 == 1) chk("busy_rise", busy, 1);
            if (done) begin seen = 1'b1; lat = cyc - c0; end
        end
        clk_en = 1'b1;
        last_lat = lat;
        chk("done_seen", seen, 1);
        if (seen) begin
            if (!exp_err) begin
                exp_lat = 6 + 2*ls + 2*lm + ((lc > 2*lm + 1) ? lc : 2*lm + 1)
                          + (stall_at >= 0 ? 5 : 0);
                chk("latency", lat, exp_lat);
            end
            chk("result", result, ex);
            chk("error", error, exp_err);
            chk("busy_at_done", busy, 1);
            if (poke) begin start = 1'b1; dataa = x ^ 32'h1; end
            @(posedge clock); #1; start = 1'b0;
            @(negedge clock);
            chk("done_pulse", done, 0);
            chk("result_hold", result, ex);
            if (poke) begin
                n = 0;
                repeat (40) begin @(negedge clock); if (done || busy) n++; end
                chk("no_extra_req", n, 0);
            end
        end
    endtask

    initial begin
        int n;
        logic [31:0] x;
        reset = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_error", error, 0);
        chk("rst_result", result, 0);
        chk("rst_starts", {as_start, mul_start, cos_start}, 0);
        reset = 1'b1;

        run(32'h4300_0000, -1, 0, 0);
        chk("x128_result", result, 32'h4680_8000);
        chk("x128_latency", last_lat, 21);

        run(32'h0000_0000, -1, 0, 0);
        chk("x0_result", result, 32'h0000_0000);
        chk("x0_cos_arg", last_cos_arg, 32'hBF80_0000);

        repeat (8) run(rand_x(), -1, 0, 0);

        lc = 12;
        run(rand_x(), -1, 0, 0);
        chk("slow_cos_latency", last_lat, 28);
        lc = 4;

        run(32'h4300_0000, 6, 0, 0);
        chk("stall_latency", last_lat, 26);
        chk("stall_result", result, 32'h4680_8000);

        mul_hang = 1'b1;
        run(rand_x(), -1, 0, 1);
        mul_hang = 1'b0;
        run(rand_x(), -1, 0, 0);

        // Stray done pulses while idle must not start anything.
        @(posedge clock); #1;
        inj_as = 1'b1; inj_mul = 1'b1; inj_cos = 1'b1;
        @(posedge clock); #1;
        inj_as = 1'b0; inj_mul = 1'b0; inj_cos = 1'b0;
        n = 0;
        repeat (4) begin @(negedge clock); if (done || busy) n++; end
        chk("idle_done_ignored", n, 0);

        // Abort during WAIT_COS (slow cosine keeps the FSM there).
        lc = 12;
        run(rand_x(), -1, 0, 0);
        x = rand_x();
        @(posedge clock); #1;
        start = 1'b1; dataa = x;
        @(posedge clock); #1;
        start = 1'b0;
        repeat (15) @(posedge clock);
        #1;
        reset = 1'b0;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        chk("abort_error", error, 0);
        chk("abort_mul_ops", mul_a | mul_b, 0);
        chk("abort_cos_arg", cos_arg, 0);
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        n = 0;
        repeat (40) begin @(negedge clock); if (done) n++; end
        chk("abort_no_done", n, 0);
        run(x, -1, 1, 0);
        lc = 4;
        run(rand_x(), -1, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
